riscv_soft_alu_arbiter: RTL and testbench
=========================================

Name: riscv_soft_alu_arbiter

Overview:
- Shares one riscv_soft_alu instance between two requesters (port 0 and port 1, e.g. the integer pipe and the branch/address unit).
- Uses valid/ready request and response handshakes with round-robin arbitration.
- Operands are registered into the ALU and the result is held in a response register until the owning requester consumes it.
- Processes one operation at a time; requests are accepted only while idle.

Parameters:
- XPR_LEN, 32, datapath width; passed through to the ALU instance.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle when valid && ready
- req0_op  input  4  port 0 ALU operation (`ALU_OP_* encoding)
- req0_op1  input  XPR_LEN  port 0 operand 1
- req0_op2  input  XPR_LEN  port 0 operand 2
- req1_valid, req1_ready, req1_op, req1_op1, req1_op2  as port 0, for port 1
- resp0_valid  output  1  result available for port 0
- resp0_ready  input  1  port 0 consumes result
- resp1_valid  output  1  result available for port 1
- resp1_ready  input  1  port 1 consumes result
- resp_result  output  XPR_LEN  shared result bus; valid only with respN_valid
- resp_cmp_true  output  1  bit 0 of resp_result
- busy  output  1  high in EXEC or RESP

Behaviour:
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all outputs 0, last_grant=1, operand/op/owner/result registers 0.
- Grant (combinational, IDLE only):
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - Neither valid: no grant.
- reqN_ready = (state==IDLE) && grantN. Ready never depends on the granted port's own op or operand values. At most one ready is high per cycle.
- IDLE -> EXEC on a request handshake:
  - Latch op, op1, op2 and owner.
  - Set last_grant=owner.
- EXEC (exactly 1 cycle): the ALU evaluates the latched operands combinationally; the result is captured into the response register. EXEC -> RESP.
- RESP:
  - resp<owner>_valid=1; the other resp valid is 0.
  - resp_result and resp_cmp_true stay stable while held.
  - On resp<owner>_ready, -> IDLE.
  - The ready of the non-owner port is ignored.
- Latency: request handshake in cycle N -> respN_valid high from cycle N+2. Best throughput is 1 op per 3 cycles.
- ALU semantics are unchanged:
  - Shifts use only op2[log2(XPR_LEN)-1:0].
  - Compares yield 0/1 zero-extended.
  - Unknown op yields 0.
- Requesters hold valid and payload stable until ready. A payload change before handshake is harmless (only the handshake cycle is sampled).
- Fairness:
  - Under continuous contention, grants strictly alternate.
  - A port waits at most one other operation before its own.
- Simultaneous events:
  - Request valids during EXEC/RESP see ready=0 and are not accepted.
  - A new request is accepted no earlier than the cycle after RESP completes.
- reset_n low at any time clears state immediately (asynchronous):
  - An in-flight op is dropped with no response.
  - resp valids drop without waiting for clk.
- Reset deassertion is synchronised externally. The block makes no assumption beyond clean release relative to clk.

Test Plan:
- Port 0 only: ADD op1=5, op2=7 -> req0_ready in cycle N; resp0_valid at N+2 with result=12, cmp_true=0; resp1_valid stays 0.
- Both ports valid in the same IDLE cycle after reset: port 0 SLT op1=0xFFFFFFFF, op2=1; port 1 SRA op1=0x80000000, op2=4 -> port 0 granted first with result 1 (cmp_true=1); port 1 granted next with result 0xF8000000.
- Continuous contention on both ports for 6 ops -> grant order 0,1,0,1,0,1; no port receives two consecutive grants.
- Response backpressure: resp1_ready held low for 5 cycles, SUB op1=3, op2=5 -> resp1_valid and result 0xFFFFFFFE held stable for 5 cycles; req0_ready stays 0 throughout; IDLE is reached the cycle after resp1_ready=1.
- Boundary ops: SLL op1=1, op2=33 -> result 2; undefined op code -> result 0; SGEU op1=0x80000000, op2=1 -> result 1.
- Reset during RESP (reset_n pulsed low asynchronously while resp0_valid=1) -> resp0_valid, busy and resp_result go to 0 immediately. After release, a tie grants port 0 and the next op completes normally.

Source files
------------

// File: rtl/riscv_soft_alu_arbiter.sv
// Two-port round-robin front end for a single riscv_soft_alu: one operation in
// flight, operands registered into the ALU, result held until the owner takes it.

module riscv_soft_alu #(
  parameter int XPR_LEN = 32
) (
  input  logic [3:0]         op,
  input  logic [XPR_LEN-1:0] in1,
  input  logic [XPR_LEN-1:0] in2,
  output logic [XPR_LEN-1:0] out
);

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SLL  = 4'd1;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_SRL  = 4'd5;
  localparam logic [3:0] ALU_OP_OR   = 4'd6;
  localparam logic [3:0] ALU_OP_AND  = 4'd7;
  localparam logic [3:0] ALU_OP_SEQ  = 4'd8;
  localparam logic [3:0] ALU_OP_SNE  = 4'd9;
  localparam logic [3:0] ALU_OP_SUB  = 4'd10;
  localparam logic [3:0] ALU_OP_SRA  = 4'd11;
  localparam logic [3:0] ALU_OP_SLT  = 4'd12;
  localparam logic [3:0] ALU_OP_SGE  = 4'd13;
  localparam logic [3:0] ALU_OP_SLTU = 4'd14;
  localparam logic [3:0] ALU_OP_SGEU = 4'd15;

  localparam int SHAMT_W = $clog2(XPR_LEN);

  // Shift amounts deliberately ignore the upper bits of operand 2
  logic [SHAMT_W-1:0] shamt;
  assign shamt = in2[SHAMT_W-1:0];

  always_comb begin
    out = '0;
    case (op)
      ALU_OP_ADD:  out = in1 + in2;
      ALU_OP_SLL:  out = in1 << shamt;
      ALU_OP_XOR:  out = in1 ^ in2;
      ALU_OP_SRL:  out = in1 >> shamt;
      ALU_OP_OR:   out = in1 | in2;
      ALU_OP_AND:  out = in1 & in2;
      ALU_OP_SEQ:  out = {{(XPR_LEN-1){1'b0}}, in1 == in2};
      ALU_OP_SNE:  out = {{(XPR_LEN-1){1'b0}}, in1 != in2};
      ALU_OP_SUB:  out = in1 - in2;
      ALU_OP_SRA:  out = $signed(in1) >>> shamt;
      ALU_OP_SLT:  out = {{(XPR_LEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      ALU_OP_SGE:  out = {{(XPR_LEN-1){1'b0}}, $signed(in1) >= $signed(in2)};
      ALU_OP_SLTU: out = {{(XPR_LEN-1){1'b0}}, in1 < in2};
      ALU_OP_SGEU: out = {{(XPR_LEN-1){1'b0}}, in1 >= in2};
      default:     out = '0;
    endcase
  end

endmodule

module riscv_soft_alu_arbiter #(
  parameter int XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [3:0]         req0_op,
  input  logic [XPR_LEN-1:0] req0_op1,
  input  logic [XPR_LEN-1:0] req0_op2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [3:0]         req1_op,
  input  logic [XPR_LEN-1:0] req1_op1,
  input  logic [XPR_LEN-1:0] req1_op2,
  output logic               resp0_valid,
  input  logic               resp0_ready,
  output logic               resp1_valid,
  input  logic               resp1_ready,
  output logic [XPR_LEN-1:0] resp_result,
  output logic               resp_cmp_true,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic               last_grant;
  logic               owner;
  logic [3:0]         op_q;
  logic [XPR_LEN-1:0] op1_q;
  logic [XPR_LEN-1:0] op2_q;
  logic [XPR_LEN-1:0] result_q;
  logic [XPR_LEN-1:0] alu_out;
  logic               grant0;
  logic               grant1;
  logic               owner_ready;

  // On a tie the port that did not win last time gets the ALU
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready    = (state == IDLE) && grant0;
  assign req1_ready    = (state == IDLE) && grant1;
  assign owner_ready   = owner ? resp1_ready : resp0_ready;
  assign resp_result   = result_q;
  assign resp_cmp_true = result_q[0];

  riscv_soft_alu #(
    .XPR_LEN (XPR_LEN)
  ) u_alu (
    .op  (op_q),
    .in1 (op1_q),
    .in2 (op2_q),
    .out (alu_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      op_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      result_q    <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_q       <= grant1 ? req1_op  : req0_op;
            op1_q      <= grant1 ? req1_op1 : req0_op1;
            op2_q      <= grant1 ? req1_op2 : req0_op2;
            owner      <= grant1;
            last_grant <= grant1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_out;
          resp0_valid <= !owner;
          resp1_valid <= owner;
          state       <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_soft_alu_arbiter.sv
// Scoreboard bench for riscv_soft_alu_arbiter: drivers push expected results at
// each request handshake, a negedge monitor checks readies, responses and busy.

module tb_riscv_soft_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_BAD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SEQ  = 4'd8;
  localparam logic [3:0] OP_SNE  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;
  localparam logic [3:0] OP_SGE  = 4'd13;
  localparam logic [3:0] OP_SLTU = 4'd14;
  localparam logic [3:0] OP_SGEU = 4'd15;

  typedef struct {
    int          port;
    logic [31:0] result;
    int          hs_cycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp_result;
  logic        resp_cmp_true;
  logic        busy;

  int   compared = 0;
  int   failed = 0;
  int   cycle = 0;
  int   resp_mode = 1;
  exp_t exp_q[$];
  int   grant_log[$];
  logic last_grant_m = 1'b1;
  logic model_idle, g0, g1, v0, v1;

  riscv_soft_alu_arbiter #(.XPR_LEN(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_op       (req0_op),
    .req0_op1      (req0_op1),
    .req0_op2      (req0_op2),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_op       (req1_op),
    .req1_op1      (req1_op1),
    .req1_op2      (req1_op2),
    .resp0_valid   (resp0_valid),
    .resp0_ready   (resp0_ready),
    .resp1_valid   (resp1_valid),
    .resp1_ready   (resp1_ready),
    .resp_result   (resp_result),
    .resp_cmp_true (resp_cmp_true),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(posedge clk) begin
    #1;
    if (resp_mode == 0) begin
      resp0_ready = 1'($urandom_range(0, 1));
      resp1_ready = 1'($urandom_range(0, 1));
    end else if (resp_mode == 1) begin
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
    end
  end

  // Reference ALU written from the operation definitions, using 64-bit signed math
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    longint      sa, sb;
    logic [63:0] wide;
    sh = {27'b0, b[4:0]};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wide = 64'(sa >>> sh);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return wide[31:0];
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SEQ:  return {31'b0, a == b};
      OP_SNE:  return {31'b0, a != b};
      OP_SLT:  return {31'b0, sa < sb};
      OP_SGE:  return {31'b0, sa >= sb};
      OP_SLTU: return {31'b0, a < b};
      OP_SGEU: return {31'b0, a >= b};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h",
               name, cycle, actual, expected);
    end
  endtask

  task automatic drivePort(input int port, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_valid = v; req1_op = op; req1_op1 = a; req1_op2 = b;
    end
  endtask

  // Holds a request until accepted; returns just after the accepting clock edge
  task automatic applyStimulus(input int port, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic use_exp,
                               input logic [31:0] exp_val, input logic jitter);
    logic accepted;
    exp_t e;
    accepted = 1'b0;
    drivePort(port, 1'b1, op, a, b);
    for (int t = 0; t < 300 && !accepted; t++) begin
      @(negedge clk);
      if (reset_n && ((port == 0) ? req0_ready : req1_ready)) begin
        e.port     = port;
        e.result   = use_exp ? exp_val : alu_model(op, a, b);
        e.hs_cycle = cycle;
        exp_q.push_back(e);
        grant_log.push_back(port);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!accepted && jitter && $urandom_range(0, 1) == 1) begin
        op = 4'($urandom_range(0, 15));
        a  = rand_operand();
        b  = rand_operand();
        drivePort(port, 1'b1, op, a, b);
      end
    end
    if (!accepted) checkOutput($sformatf("handshake_timeout_p%0d", port), 32'd0, 32'd1);
    drivePort(port, 1'b0, op, a, b);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) checkOutput({name, "_drain_timeout"}, 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    drivePort(0, 1'b0, OP_ADD, 32'h0, 32'h0);
    drivePort(1, 1'b0, OP_ADD, 32'h0, 32'h0);
    exp_q.delete();
    last_grant_m = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Cycle-level model: readies from round-robin rules, responses from the queue
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      model_idle = (exp_q.size() == 0) || (exp_q[0].hs_cycle == cycle);
      g0 = model_idle && req0_valid && (!req1_valid || last_grant_m);
      g1 = model_idle && req1_valid && (!req0_valid || !last_grant_m);
      checkOutput("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
      checkOutput("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
      if (g0) last_grant_m = 1'b0;
      if (g1) last_grant_m = 1'b1;
      v0 = 1'b0;
      v1 = 1'b0;
      if (exp_q.size() != 0 && cycle >= exp_q[0].hs_cycle + 2) begin
        v0 = (exp_q[0].port == 0);
        v1 = (exp_q[0].port == 1);
      end
      checkOutput("resp0_valid", {31'b0, resp0_valid}, {31'b0, v0});
      checkOutput("resp1_valid", {31'b0, resp1_valid}, {31'b0, v1});
      checkOutput("busy", {31'b0, busy}, {31'b0, !model_idle});
      if (v0 || v1) begin
        checkOutput("resp_result", resp_result, exp_q[0].result);
        checkOutput("resp_cmp_true", {31'b0, resp_cmp_true}, {31'b0, exp_q[0].result[0]});
        if ((v0 && resp0_ready) || (v1 && resp1_ready)) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    resp_mode = 1;
    #3;
    checkOutput("rst_resp0_valid", {31'b0, resp0_valid}, 32'd0);
    checkOutput("rst_resp1_valid", {31'b0, resp1_valid}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_result", resp_result, 32'd0);
    checkOutput("rst_cmp_true", {31'b0, resp_cmp_true}, 32'd0);
    checkOutput("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    checkOutput("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    doReset();

    // Tie straight after reset: port 0 wins first
    grant_log.delete();
    fork
      applyStimulus(0, OP_SLT, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h1, 1'b0);
      applyStimulus(1, OP_SRA, 32'h8000_0000, 32'h4, 1'b1, 32'hF800_0000, 1'b0);
    join
    waitDrain("tie");
    checkOutput("tie_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      checkOutput("tie_first", grant_log[0], 0);
      checkOutput("tie_second", grant_log[1], 1);
    end

    // Continuous contention: grants must alternate 0,1,0,1,0,1
    grant_log.delete();
    fork
      for (int i = 0; i < 3; i++) applyStimulus(0, OP_ADD, 32'(i), 32'h10, 1'b1, 32'(i + 16), 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1, OP_XOR, 32'(i), 32'hFF, 1'b1, 32'(i) ^ 32'hFF, 1'b0);
    join
    waitDrain("contention");
    checkOutput("cont_grants", grant_log.size(), 6);
    for (int i = 0; i < grant_log.size(); i++)
      checkOutput($sformatf("cont_order_%0d", i), grant_log[i], i % 2);

    applyStimulus(0, OP_ADD, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0);
    waitDrain("add");

    // Response backpressure on port 1 while port 0 waits
    resp_mode = 2;
    resp0_ready = 1'b1;
    resp1_ready = 1'b0;
    applyStimulus(1, OP_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0);
    fork
      applyStimulus(0, OP_OR, 32'hF0, 32'h0F, 1'b1, 32'hFF, 1'b0);
      begin
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          #2;
          checkOutput("bp_resp1_valid", {31'b0, resp1_valid}, 32'd1);
          checkOutput("bp_result", resp_result, 32'hFFFF_FFFE);
          checkOutput("bp_req0_ready", {31'b0, req0_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        resp1_ready = 1'b1;
        @(negedge clk);
        #2;
        @(negedge clk);
        #2;
        checkOutput("bp_idle_req0_ready", {31'b0, req0_ready}, 32'd1);
      end
    join
    waitDrain("backpressure");
    resp_mode = 1;

    applyStimulus(0, OP_SLL, 32'd1, 32'd33, 1'b1, 32'd2, 1'b0);
    applyStimulus(1, OP_BAD, 32'h1234_5678, 32'h9, 1'b1, 32'd0, 1'b0);
    applyStimulus(0, OP_SGEU, 32'h8000_0000, 32'd1, 1'b1, 32'd1, 1'b0);
    waitDrain("boundary");

    // Randomised traffic with response backpressure and payload churn
    resp_mode = 0;
    fork
      for (int i = 0; i < 20; i++) begin
        applyStimulus(0, 4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 1'b0, 32'h0, 1'b1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 20; i++) begin
        applyStimulus(1, 4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 1'b0, 32'h0, 1'b1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    join
    resp_mode = 1;
    waitDrain("random");

    // Asynchronous reset while a response is held
    resp_mode = 2;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    applyStimulus(0, OP_ADD, 32'h1234, 32'h1, 1'b1, 32'h1235, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_resp0_valid", {31'b0, resp0_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_resp0_valid", {31'b0, resp0_valid}, 32'd0);
    checkOutput("async_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_result", resp_result, 32'd0);
    checkOutput("async_cmp_true", {31'b0, resp_cmp_true}, 32'd0);
    exp_q.delete();
    last_grant_m = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    resp_mode = 1;
    grant_log.delete();
    fork
      applyStimulus(0, OP_ADD, 32'd10, 32'd20, 1'b1, 32'd30, 1'b0);
      applyStimulus(1, OP_SEQ, 32'd7, 32'd7, 1'b1, 32'd1, 1'b0);
    join
    waitDrain("post_reset");
    checkOutput("post_reset_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) checkOutput("post_reset_first", grant_log[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
